saxi_check: RTL and testbench

- AXI3 slave traffic checker and responder for the fhtest bench.
- Sits directly downstream of the bench AXI master traffic generator and terminates its five channels.
- Accepts single-beat writes and checks them against the generator's pattern: address +4 from 0, data -1 from all-ones.
- Accepts single-beat reads, checks address +8 from 0, and returns address-echo data.
- Reports sticky ERROR, a first-error code, and DONE after a programmed number of transfers.

---
 rtl/saxi_check_if.sv | 78 +++++++
 rtl/saxi_check.sv | 217 +++++++++++++++++++++
 tb/tb_saxi_check.sv | 485 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/saxi_check_if.sv
// AXI3 slave-side bundle for saxi_check: the five channels between the bench
// traffic generator (master) and the checker/responder (slave).
interface saxi_check_if #(
   parameter int SIDW = 12,
   parameter int SAW  = 32,
   parameter int SDW  = 32,
   parameter int SSTW = 8
);
   // write address channel
   logic [SIDW-1:0] awid;
   logic [SAW-1:0]  awaddr;
   logic [3:0]      awlen;
   logic [2:0]      awsize;
   logic [1:0]      awburst;
   logic [1:0]      awlock;
   logic [3:0]      awcache;
   logic [2:0]      awprot;
   logic [3:0]      awqos;
   logic            awvalid;
   logic            awready;
   // write data channel
   logic [SIDW-1:0] wid;
   logic [SDW-1:0]  wdata;
   logic [SSTW-1:0] wstrb;
   logic            wlast;
   logic            wvalid;
   logic            wready;
   // write response channel
   logic [SIDW-1:0] bid;
   logic [1:0]      bresp;
   logic            bvalid;
   logic            bready;
   // read address channel
   logic [SIDW-1:0] arid;
   logic [SAW-1:0]  araddr;
   logic [3:0]      arlen;
   logic [2:0]      arsize;
   logic [1:0]      arburst;
   logic [1:0]      arlock;
   logic [3:0]      arcache;
   logic [2:0]      arprot;
   logic [3:0]      arqos;
   logic            arvalid;
   logic            arready;
   // read data channel
   logic [SIDW-1:0] rid;
   logic [SDW-1:0]  rdata;
   logic [1:0]      rresp;
   logic            rlast;
   logic            rvalid;
   logic            rready;

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
      input  awready,
      output wid, wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready,
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready
   );

   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
      output awready,
      input  wid, wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready,
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready
   );
endinterface

// File: rtl/saxi_check.sv
// AXI3 slave traffic checker/responder. Terminates single-beat writes and
// reads from the bench generator, checks them against the generator's
// address/data pattern, echoes read addresses as data, and reports a sticky
// error with the code of the first failure plus a DONE flag.
module saxi_check #(
   parameter int SIDW  = 12,
   parameter int SAW   = 32,
   parameter int SDW   = 32,
   parameter int SSTW  = 8,
   parameter int NUM_W = 256,
   parameter int NUM_R = 256
) (
   input  logic               s_axi_aclk,
   input  logic               s_axi_aresetn,
   saxi_check_if.slave        s_axi,
   output logic               ERROR,
   output logic [2:0]         ERR_CODE,
   output logic               DONE
);
   localparam int SB  = SDW / 8;
   localparam int WCW = $clog2(NUM_W + 1);
   localparam int RCW = $clog2(NUM_R + 1);
   localparam logic [WCW-1:0] W_MAX = WCW'(NUM_W);
   localparam logic [RCW-1:0] R_MAX = RCW'(NUM_R);

   logic            r_live;
   logic            r_aw_full, r_w_full, r_ar_full;
   logic [SIDW-1:0] r_awid, r_arid;
   logic [SAW-1:0]  r_awaddr, r_araddr;
   logic [3:0]      r_awlen, r_arlen;
   logic [2:0]      r_awsize, r_arsize;
   logic [SDW-1:0]  r_wdata;
   logic [SB-1:0]   r_wstrb;
   logic            r_wlast;
   logic            r_bvalid, r_rvalid, r_rlast;
   logic [SIDW-1:0] r_bid, r_rid;
   logic [1:0]      r_bresp, r_rresp;
   logic [SDW-1:0]  r_rdata;
   logic [SAW-1:0]  r_exp_waddr, r_exp_raddr;
   logic [SDW-1:0]  r_exp_wdata;
   logic [WCW-1:0]  r_wcount;
   logic [RCW-1:0]  r_rcount;
   logic            r_error, r_done;
   logic [2:0]      r_err_code;

   logic            w_aw_hs, w_w_hs, w_ar_hs;
   logic            w_wr_fire, w_rd_fire;
   logic [2:0]      w_wcode, w_rcode, w_code;
   logic            w_done_now;

   // Readies come straight from state, so a slot is never captured and
   // released on the same edge.
   assign s_axi.awready = r_live & ~r_aw_full;
   assign s_axi.wready  = r_live & ~r_w_full;
   assign s_axi.arready = r_live & ~r_ar_full;

   assign w_aw_hs   = s_axi.awvalid & s_axi.awready;
   assign w_w_hs    = s_axi.wvalid & s_axi.wready;
   assign w_ar_hs   = s_axi.arvalid & s_axi.arready;
   assign w_wr_fire = r_aw_full & r_w_full & (~r_bvalid | s_axi.bready);
   assign w_rd_fire = r_ar_full & (~r_rvalid | s_axi.rready);

   // Hold readies low until the first edge after reset release.
   // NOTE: all sequential state uses non-blocking assignment so every block
   // sees pre-edge values regardless of evaluation order.
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) r_live <= 1'b0;
      else                r_live <= 1'b1;
   end

   // Write-address holding slot: fill on handshake, empty on write completion.
   // NOTE: holding-slot fields are reset too, so the B/R outputs built from
   // them are deterministic even before the first transfer.
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         r_aw_full <= 1'b0;
         r_awid    <= '0;
         r_awaddr  <= '0;
         r_awlen   <= '0;
         r_awsize  <= '0;
      end else if (w_aw_hs) begin
         r_aw_full <= 1'b1;
         r_awid    <= s_axi.awid;
         r_awaddr  <= s_axi.awaddr;
         r_awlen   <= s_axi.awlen;
         r_awsize  <= s_axi.awsize;
      end else if (w_wr_fire) begin
         r_aw_full <= 1'b0;
      end
   end

   // Write-data holding slot; only the byte lanes inside SDW are kept.
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         r_w_full <= 1'b0;
         r_wdata  <= '0;
         r_wstrb  <= '0;
         r_wlast  <= 1'b0;
      end else if (w_w_hs) begin
         r_w_full <= 1'b1;
         r_wdata  <= s_axi.wdata;
         r_wstrb  <= s_axi.wstrb[SB-1:0];
         r_wlast  <= s_axi.wlast;
      end else if (w_wr_fire) begin
         r_w_full <= 1'b0;
      end
   end

   // Read-address holding slot: fill on handshake, empty on read completion.
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         r_ar_full <= 1'b0;
         r_arid    <= '0;
         r_araddr  <= '0;
         r_arlen   <= '0;
         r_arsize  <= '0;
      end else if (w_ar_hs) begin
         r_ar_full <= 1'b1;
         r_arid    <= s_axi.arid;
         r_araddr  <= s_axi.araddr;
         r_arlen   <= s_axi.arlen;
         r_arsize  <= s_axi.arsize;
      end else if (w_rd_fire) begin
         r_ar_full <= 1'b0;
      end
   end

   // Write response, expected write pattern and saturating write count.
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         r_bvalid    <= 1'b0;
         r_bid       <= '0;
         r_bresp     <= '0;
         r_exp_waddr <= '0;
         r_exp_wdata <= '1;
         r_wcount    <= '0;
      end else if (w_wr_fire) begin
         r_bvalid    <= 1'b1;
         r_bid       <= r_awid;
         r_bresp     <= (r_awlen != 4'd0) ? 2'b10 : 2'b00;
         r_exp_waddr <= r_exp_waddr + SAW'(4);
         r_exp_wdata <= r_exp_wdata - SDW'(1);
         if (r_wcount != W_MAX) r_wcount <= r_wcount + WCW'(1);
      end else if (r_bvalid & s_axi.bready) begin
         r_bvalid <= 1'b0;
      end
   end

   // Read response (address echo), expected read address and read count.
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         r_rvalid    <= 1'b0;
         r_rid       <= '0;
         r_rdata     <= '0;
         r_rresp     <= '0;
         r_rlast     <= 1'b0;
         r_exp_raddr <= '0;
         r_rcount    <= '0;
      end else if (w_rd_fire) begin
         r_rvalid    <= 1'b1;
         r_rid       <= r_arid;
         r_rdata     <= SDW'(r_araddr);
         r_rresp     <= (r_arlen != 4'd0) ? 2'b10 : 2'b00;
         r_rlast     <= 1'b1;
         r_exp_raddr <= r_exp_raddr + SAW'(8);
         if (r_rcount != R_MAX) r_rcount <= r_rcount + RCW'(1);
      end else if (r_rvalid & s_axi.rready) begin
         r_rvalid <= 1'b0;
      end
   end

   // Classify completing transfers; lowest code wins, write side before read.
   always_comb begin
      w_wcode = 3'd0;
      w_rcode = 3'd0;
      if (w_wr_fire) begin
         if (r_awaddr != r_exp_waddr)     w_wcode = 3'd1;
         else if (r_wdata != r_exp_wdata) w_wcode = 3'd2;
         else if (r_awlen != 4'd0 || !r_wlast || r_awsize != 3'd2 || r_wstrb != '1)
            w_wcode = 3'd3;
      end
      if (w_rd_fire) begin
         if (r_araddr != r_exp_raddr)                    w_rcode = 3'd4;
         else if (r_arlen != 4'd0 || r_arsize != 3'd2)   w_rcode = 3'd5;
      end
      w_code = (w_wcode != 3'd0) ? w_wcode : w_rcode;
   end

   assign w_done_now = (r_wcount == W_MAX) & (r_rcount == R_MAX) & ~r_bvalid & ~r_rvalid;

   // Sticky error flag, first error code, and sticky DONE.
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         r_error    <= 1'b0;
         r_err_code <= '0;
         r_done     <= 1'b0;
      end else begin
         if (!r_error && w_code != 3'd0) begin
            r_error    <= 1'b1;
            r_err_code <= w_code;
         end
         if (w_done_now) r_done <= 1'b1;
      end
   end

   assign s_axi.bvalid = r_bvalid;
   assign s_axi.bid    = r_bid;
   assign s_axi.bresp  = r_bresp;
   assign s_axi.rvalid = r_rvalid;
   assign s_axi.rid    = r_rid;
   assign s_axi.rdata  = r_rdata;
   assign s_axi.rresp  = r_rresp;
   assign s_axi.rlast  = r_rlast;
   assign ERROR        = r_error;
   assign ERR_CODE     = r_err_code;
   assign DONE         = r_done;
endmodule

// File: tb/tb_saxi_check.sv
// Self-checking bench for saxi_check: directed reset/latency/backpressure
// sequences, a vector table of single transfers, and randomized traffic
// compared against a transaction-level model of the generator pattern.
module tb_saxi_check;
   localparam int SIDW = 12;
   localparam int SAW  = 32;
   localparam int SDW  = 32;
   localparam int SSTW = 8;
   localparam int NUM  = 4;
   localparam int NR   = 24;
   localparam int BUDGET = 3000;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       error;
   logic [2:0] err_code;
   logic       done;
   int         n_checks = 0;
   int         n_errors = 0;

   saxi_check_if #(.SIDW(SIDW), .SAW(SAW), .SDW(SDW), .SSTW(SSTW)) bus ();

   saxi_check #(
      .SIDW(SIDW), .SAW(SAW), .SDW(SDW), .SSTW(SSTW), .NUM_W(NUM), .NUM_R(NUM)
   ) dut (
      .s_axi_aclk    (clk),
      .s_axi_aresetn (rst_n),
      .s_axi         (bus),
      .ERROR         (error),
      .ERR_CODE      (err_code),
      .DONE          (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [SIDW-1:0] id;
      logic [31:0]     addr;
      logic [31:0]     data;
      logic [3:0]      len;
      logic [2:0]      size;
      logic [7:0]      strb;
      logic            last;
   } wtx_t;

   typedef struct {
      logic [SIDW-1:0] id;
      logic [31:0]     addr;
      logic [3:0]      len;
      logic [2:0]      size;
   } rtx_t;

   typedef struct {
      logic        is_rd;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  len;
      logic [2:0]  size;
      logic [7:0]  strb;
      logic        last;
      logic [31:0] exp_data;
      logic [1:0]  exp_resp;
      logic        exp_err;
      logic [2:0]  exp_code;
      logic        exp_done;
   } vec_t;

   wtx_t wq[NR];
   rtx_t rq[NR];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_timeout(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s: timed out, handshake never completed", name);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
      bus.awlock = '0; bus.awcache = '0; bus.awprot = '0; bus.awqos = '0; bus.awvalid = 1'b0;
      bus.wid = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
      bus.bready = 1'b0;
      bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
      bus.arlock = '0; bus.arcache = '0; bus.arprot = '0; bus.arqos = '0; bus.arvalid = 1'b0;
      bus.rready = 1'b0;
   endtask

   // Reset, release, and step past the edge that sets the DUT live.
   task automatic do_reset();
      rst_n = 1'b0;
      idle_inputs();
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic do_write(input logic [SIDW-1:0] id, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] len, input logic [2:0] size, input logic [7:0] strb,
                           input logic last, output logic [SIDW-1:0] bid, output logic [1:0] bresp);
      int   cyc;
      logic aw_hs, w_hs;
      bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = size; bus.awburst = 2'b01;
      bus.wid = id; bus.wdata = data; bus.wstrb = strb; bus.wlast = last;
      bus.awvalid = 1'b1;
      bus.wvalid  = 1'b1;
      cyc = 0;
      while ((bus.awvalid || bus.wvalid) && cyc < 50) begin
         aw_hs = bus.awvalid & bus.awready;
         w_hs  = bus.wvalid & bus.wready;
         tick();
         if (aw_hs) bus.awvalid = 1'b0;
         if (w_hs)  bus.wvalid  = 1'b0;
         cyc++;
      end
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      if (cyc >= 50) fail_timeout("write_addr_data");
      bus.bready = 1'b1;
      cyc = 0;
      while (!bus.bvalid && cyc < 50) begin
         tick();
         cyc++;
      end
      if (cyc >= 50) fail_timeout("write_resp");
      bid   = bus.bid;
      bresp = bus.bresp;
      tick();
      bus.bready = 1'b0;
   endtask

   task automatic do_read(input logic [SIDW-1:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, output logic [SIDW-1:0] rid, output logic [31:0] rdata,
                          output logic [1:0] rresp, output logic rlast);
      int cyc;
      bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arburst = 2'b01;
      bus.arvalid = 1'b1;
      cyc = 0;
      while (!bus.arready && cyc < 50) begin
         tick();
         cyc++;
      end
      if (cyc >= 50) fail_timeout("read_addr");
      tick();
      bus.arvalid = 1'b0;
      bus.rready  = 1'b1;
      cyc = 0;
      while (!bus.rvalid && cyc < 50) begin
         tick();
         cyc++;
      end
      if (cyc >= 50) fail_timeout("read_data");
      rid   = bus.rid;
      rdata = bus.rdata;
      rresp = bus.rresp;
      rlast = bus.rlast;
      tick();
      bus.rready = 1'b0;
   endtask

   // ---------------- reference model (transaction level) ----------------
   // The k-th write must target 4*k with data all-ones minus k; the k-th read 8*k.
   function automatic logic [2:0] wr_code(input int k);
      if (wq[k].addr != 32'(4 * k))                 return 3'd1;
      if (wq[k].data != 32'hFFFF_FFFF - 32'(k))     return 3'd2;
      if (wq[k].len != 0 || !wq[k].last || wq[k].size != 3'd2 || wq[k].strb[3:0] != 4'hF)
         return 3'd3;
      return 3'd0;
   endfunction

   function automatic logic [2:0] rd_code(input int k);
      if (rq[k].addr != 32'(8 * k))                return 3'd4;
      if (rq[k].len != 0 || rq[k].size != 3'd2)    return 3'd5;
      return 3'd0;
   endfunction

   // ---------------- random traffic processes ----------------
   task automatic drive_aw();
      int cyc;
      for (int k = 0; k < NR; k++) begin
         repeat ($urandom_range(0, 2)) tick();
         bus.awid = wq[k].id; bus.awaddr = wq[k].addr; bus.awlen = wq[k].len; bus.awsize = wq[k].size;
         bus.awburst = 2'($urandom); bus.awlock = 2'($urandom); bus.awcache = 4'($urandom);
         bus.awprot = 3'($urandom); bus.awqos = 4'($urandom);
         bus.awvalid = 1'b1;
         cyc = 0;
         while (!bus.awready && cyc < BUDGET) begin tick(); cyc++; end
         if (cyc >= BUDGET) begin fail_timeout("rand_aw"); bus.awvalid = 1'b0; return; end
         tick();
         bus.awvalid = 1'b0;
      end
   endtask

   task automatic drive_w();
      int cyc;
      for (int k = 0; k < NR; k++) begin
         repeat ($urandom_range(0, 2)) tick();
         bus.wid = SIDW'($urandom); bus.wdata = wq[k].data; bus.wstrb = wq[k].strb; bus.wlast = wq[k].last;
         bus.wvalid = 1'b1;
         cyc = 0;
         while (!bus.wready && cyc < BUDGET) begin tick(); cyc++; end
         if (cyc >= BUDGET) begin fail_timeout("rand_w"); bus.wvalid = 1'b0; return; end
         tick();
         bus.wvalid = 1'b0;
      end
   endtask

   task automatic drive_ar();
      int cyc;
      for (int k = 0; k < NR; k++) begin
         repeat ($urandom_range(0, 2)) tick();
         bus.arid = rq[k].id; bus.araddr = rq[k].addr; bus.arlen = rq[k].len; bus.arsize = rq[k].size;
         bus.arburst = 2'($urandom); bus.arlock = 2'($urandom); bus.arcache = 4'($urandom);
         bus.arprot = 3'($urandom); bus.arqos = 4'($urandom);
         bus.arvalid = 1'b1;
         cyc = 0;
         while (!bus.arready && cyc < BUDGET) begin tick(); cyc++; end
         if (cyc >= BUDGET) begin fail_timeout("rand_ar"); bus.arvalid = 1'b0; return; end
         tick();
         bus.arvalid = 1'b0;
      end
   endtask

   task automatic sink_b();
      int              got = 0;
      int              cyc = 0;
      logic            held = 1'b0;
      logic [SIDW-1:0] prev_id = '0;
      logic [1:0]      prev_resp = '0;
      while (got < NR && cyc < BUDGET) begin
         bus.bready = ($urandom_range(0, 3) != 0);
         if (held) check("b_hold", {bus.bvalid, bus.bid, bus.bresp}, {1'b1, prev_id, prev_resp});
         if (bus.bvalid && bus.bready) begin
            check("rand_bid", 64'(bus.bid), 64'(wq[got].id));
            check("rand_bresp", 64'(bus.bresp), (wq[got].len != 0) ? 64'd2 : 64'd0);
            got++;
         end
         held      = bus.bvalid & ~bus.bready;
         prev_id   = bus.bid;
         prev_resp = bus.bresp;
         tick();
         cyc++;
      end
      bus.bready = 1'b0;
      if (got < NR) fail_timeout("rand_b");
   endtask

   task automatic sink_r();
      int          got = 0;
      int          cyc = 0;
      logic        held = 1'b0;
      logic [31:0] prev_data = '0;
      while (got < NR && cyc < BUDGET) begin
         bus.rready = ($urandom_range(0, 3) != 0);
         if (held) check("r_hold", {bus.rvalid, bus.rdata}, {1'b1, prev_data});
         if (bus.rvalid && bus.rready) begin
            check("rand_rid", 64'(bus.rid), 64'(rq[got].id));
            check("rand_rdata", 64'(bus.rdata), 64'(rq[got].addr));
            check("rand_rresp", 64'(bus.rresp), (rq[got].len != 0) ? 64'd2 : 64'd0);
            check("rand_rlast", 64'(bus.rlast), 64'd1);
            got++;
         end
         held      = bus.rvalid & ~bus.rready;
         prev_data = bus.rdata;
         tick();
         cyc++;
      end
      bus.rready = 1'b0;
      if (got < NR) fail_timeout("rand_r");
   endtask

   // One randomized run; corruption is injected on one side only so the
   // first failing transfer is unambiguous from the model.
   task automatic run_random(input bit corrupt_wr, input bit corrupt_rd);
      logic       exp_err;
      logic [2:0] exp_code;
      logic [2:0] c;
      for (int k = 0; k < NR; k++) begin
         wq[k].id = SIDW'($urandom); wq[k].addr = 32'(4 * k); wq[k].data = 32'hFFFF_FFFF - 32'(k);
         wq[k].len = 4'd0; wq[k].size = 3'd2; wq[k].strb = {4'($urandom), 4'hF}; wq[k].last = 1'b1;
         if (corrupt_wr) begin
            case ($urandom_range(0, 11))
               0: wq[k].addr = wq[k].addr + 32'h100;
               1: wq[k].data = wq[k].data ^ (32'h1 << $urandom_range(0, 31));
               2: wq[k].len  = 4'($urandom_range(1, 15));
               3: wq[k].last = 1'b0;
               4: wq[k].size = 3'($urandom_range(0, 1));
               5: wq[k].strb[$urandom_range(0, 3)] = 1'b0;
               default: ;
            endcase
         end
         rq[k].id = SIDW'($urandom); rq[k].addr = 32'(8 * k); rq[k].len = 4'd0; rq[k].size = 3'd2;
         if (corrupt_rd) begin
            case ($urandom_range(0, 7))
               0: rq[k].addr = rq[k].addr + 32'h40;
               1: rq[k].len  = 4'($urandom_range(1, 15));
               2: rq[k].size = 3'($urandom_range(3, 7));
               default: ;
            endcase
         end
      end
      exp_err  = 1'b0;
      exp_code = 3'd0;
      for (int k = 0; k < NR; k++) begin
         c = wr_code(k);
         if (!exp_err && c != 0) begin exp_err = 1'b1; exp_code = c; end
      end
      for (int k = 0; k < NR; k++) begin
         c = rd_code(k);
         if (!exp_err && c != 0) begin exp_err = 1'b1; exp_code = c; end
      end
      do_reset();
      fork
         drive_aw();
         drive_w();
         drive_ar();
         sink_b();
         sink_r();
      join
      repeat (3) tick();
      check("rand_error", 64'(error), 64'(exp_err));
      check("rand_err_code", 64'(err_code), 64'(exp_code));
      check("rand_done", 64'(done), 64'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t            tbl[12];
      logic [SIDW-1:0] id_o;
      logic [31:0]     data_o;
      logic [1:0]      resp_o;
      logic            last_o;

      // ---- 1: reset and idle ----
      idle_inputs();
      rst_n = 1'b0;
      tick();
      check("reset_outputs", {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid, error, err_code, done}, 64'd0);
      rst_n = 1'b1;
      check("ready_first_cycle", {bus.awready, bus.wready, bus.arready}, 64'd0);
      tick();
      check("ready_after_live", {bus.awready, bus.wready, bus.arready}, 64'h7);
      repeat (2) tick();
      check("idle_outputs", {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid, error, done}, 64'h70);

      // ---- 2: AW two cycles ahead of W, B latency ----
      do_reset();
      bus.bready = 1'b1;
      bus.awid = 12'h5A5; bus.awaddr = 32'h0; bus.awlen = 4'd0; bus.awsize = 3'd2; bus.awvalid = 1'b1;
      check("lat_awready", 64'(bus.awready), 64'd1);
      tick();
      bus.awvalid = 1'b0;
      repeat (2) tick();
      bus.wdata = 32'hFFFF_FFFF; bus.wstrb = 8'hFF; bus.wlast = 1'b1; bus.wvalid = 1'b1;
      check("lat_wready", 64'(bus.wready), 64'd1);
      tick();
      bus.wvalid = 1'b0;
      check("lat_bvalid_early", 64'(bus.bvalid), 64'd0);
      tick();
      check("lat_b", {bus.bvalid, bus.bid, bus.bresp, error}, {1'b1, 12'h5A5, 2'b00, 1'b0});
      tick();
      check("lat_b_cleared", 64'(bus.bvalid), 64'd0);
      bus.bready = 1'b0;

      // ---- 3: vector table of single transfers ----
      tbl[0]  = '{1'b0, 32'd0,  32'hFFFF_FFFF, 4'd0, 3'd2, 8'hFF, 1'b1, 32'd0,  2'd0, 1'b0, 3'd0, 1'b0};
      tbl[1]  = '{1'b1, 32'd0,  32'd0,         4'd0, 3'd2, 8'h00, 1'b0, 32'd0,  2'd0, 1'b0, 3'd0, 1'b0};
      tbl[2]  = '{1'b0, 32'd4,  32'hFFFF_FFFE, 4'd0, 3'd2, 8'hFF, 1'b1, 32'd0,  2'd0, 1'b0, 3'd0, 1'b0};
      tbl[3]  = '{1'b1, 32'd8,  32'd0,         4'd0, 3'd2, 8'h00, 1'b0, 32'd8,  2'd0, 1'b0, 3'd0, 1'b0};
      tbl[4]  = '{1'b0, 32'd8,  32'hFFFF_FFFD, 4'd0, 3'd2, 8'h0F, 1'b1, 32'd0,  2'd0, 1'b0, 3'd0, 1'b0};
      tbl[5]  = '{1'b1, 32'd16, 32'd0,         4'd0, 3'd2, 8'h00, 1'b0, 32'd16, 2'd0, 1'b0, 3'd0, 1'b0};
      tbl[6]  = '{1'b0, 32'd12, 32'hFFFF_FFFC, 4'd0, 3'd2, 8'hFF, 1'b1, 32'd0,  2'd0, 1'b0, 3'd0, 1'b0};
      tbl[7]  = '{1'b1, 32'd24, 32'd0,         4'd0, 3'd2, 8'h00, 1'b0, 32'd24, 2'd0, 1'b0, 3'd0, 1'b1};
      tbl[8]  = '{1'b0, 32'd16, 32'hFFFF_FFFB, 4'd0, 3'd2, 8'hF0, 1'b1, 32'd0,  2'd0, 1'b1, 3'd3, 1'b1};
      tbl[9]  = '{1'b1, 32'd32, 32'd0,         4'd0, 3'd1, 8'h00, 1'b0, 32'd32, 2'd0, 1'b1, 3'd3, 1'b1};
      tbl[10] = '{1'b0, 32'd20, 32'hFFFF_FFFA, 4'd2, 3'd2, 8'hFF, 1'b1, 32'd0,  2'd2, 1'b1, 3'd3, 1'b1};
      tbl[11] = '{1'b1, 32'd40, 32'd0,         4'd1, 3'd2, 8'h00, 1'b0, 32'd40, 2'd2, 1'b1, 3'd3, 1'b1};
      do_reset();
      for (int i = 0; i < 12; i++) begin
         if (tbl[i].is_rd) begin
            do_read(SIDW'(i + 1), tbl[i].addr, tbl[i].len, tbl[i].size, id_o, data_o, resp_o, last_o);
            check($sformatf("vec%0d_rid", i), 64'(id_o), 64'(i + 1));
            check($sformatf("vec%0d_rdata", i), 64'(data_o), 64'(tbl[i].exp_data));
            check($sformatf("vec%0d_rlast", i), 64'(last_o), 64'd1);
         end else begin
            do_write(SIDW'(i + 1), tbl[i].addr, tbl[i].data, tbl[i].len, tbl[i].size, tbl[i].strb,
                     tbl[i].last, id_o, resp_o);
            check($sformatf("vec%0d_bid", i), 64'(id_o), 64'(i + 1));
         end
         check($sformatf("vec%0d_resp", i), 64'(resp_o), 64'(tbl[i].exp_resp));
         repeat (2) tick();
         check($sformatf("vec%0d_flags", i), {error, err_code, done},
               {tbl[i].exp_err, tbl[i].exp_code, tbl[i].exp_done});
      end

      // ---- 4: first error code is kept ----
      do_reset();
      do_write(12'h1, 32'h0, 32'hFFFF_FFFF, 4'd0, 3'd2, 8'hFF, 1'b1, id_o, resp_o);
      check("err_first_ok", 64'(error), 64'd0);
      do_write(12'h2, 32'h4, 32'hFFFF_FFF0, 4'd0, 3'd2, 8'hFF, 1'b1, id_o, resp_o);
      check("err_data", {error, err_code}, {1'b1, 3'd2});
      do_write(12'h3, 32'h100, 32'hFFFF_FFFD, 4'd0, 3'd2, 8'hFF, 1'b1, id_o, resp_o);
      check("err_sticky_code", {error, err_code, resp_o}, {1'b1, 3'd2, 2'b00});

      // ---- 5: B backpressure ----
      do_reset();
      bus.awid = 12'h011; bus.awaddr = 32'h0; bus.awlen = 4'd0; bus.awsize = 3'd2; bus.awvalid = 1'b1;
      bus.wdata = 32'hFFFF_FFFF; bus.wstrb = 8'hFF; bus.wlast = 1'b1; bus.wvalid = 1'b1;
      tick();
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      tick();
      check("bp_b_first", {bus.bvalid, bus.bid}, {1'b1, 12'h011});
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_b_stable", {bus.bvalid, bus.bid, bus.bresp}, {1'b1, 12'h011, 2'b00});
      end
      bus.awid = 12'h022; bus.awaddr = 32'h4; bus.awvalid = 1'b1;
      bus.wdata = 32'hFFFF_FFFE; bus.wvalid = 1'b1;
      check("bp_awready_free", 64'(bus.awready), 64'd1);
      tick();
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("bp_held", {bus.awready, bus.bvalid, bus.bid}, {1'b0, 1'b1, 12'h011});
         tick();
      end
      bus.bready = 1'b1;
      tick();
      check("bp_b_second", {bus.bvalid, bus.bid}, {1'b1, 12'h022});
      tick();
      check("bp_b_drained", {bus.bvalid, error}, 64'd0);
      bus.bready = 1'b0;

      // ---- 6: reset with read pending ----
      do_reset();
      bus.arid = 12'h007; bus.araddr = 32'h0; bus.arlen = 4'd0; bus.arsize = 3'd2; bus.arvalid = 1'b1;
      tick();
      bus.arvalid = 1'b0;
      tick();
      check("rst_r_pending", {bus.rvalid, bus.rdata}, {1'b1, 32'h0});
      bus.araddr = 32'h8; bus.arvalid = 1'b1;
      tick();
      bus.arvalid = 1'b0;
      check("rst_ar_full", {bus.arready, bus.rvalid}, {1'b0, 1'b1});
      #2 rst_n = 1'b0;
      #1 check("rst_r_dropped", {bus.rvalid, bus.arready, error}, 64'd0);
      tick();
      rst_n = 1'b1;
      bus.rready = 1'b1;
      repeat (3) begin
         tick();
         check("rst_no_stale_r", 64'(bus.rvalid), 64'd0);
      end
      bus.rready = 1'b0;
      do_read(12'h009, 32'h0, 4'd0, 3'd2, id_o, data_o, resp_o, last_o);
      check("rst_read0", {id_o, data_o, resp_o}, {12'h009, 32'h0, 2'b00});
      tick();
      check("rst_read0_noerr", 64'(error), 64'd0);

      // ---- randomized traffic against the model ----
      run_random(1'b1, 1'b0);
      run_random(1'b0, 1'b1);
      run_random(1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
